addsub_serial: RTL and testbench



---
 rtl/addsub_serial.sv | 159 +++++++++++++++
 tb/tb_addsub_serial.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : addsub_serial
//  Description : Digit-serial two's-complement adder/subtractor. A WIDTH-bit
//                operation is processed DIGIT bits per clock, LSB digit first,
//                behind a start/done handshake. Reports result, unsigned
//                carry/borrow, signed overflow and zero. Accumulate mode uses
//                the held result as operand A.
//  Revision    : 1.0  initial release
// ============================================================================
module addsub_serial #(
    parameter int WIDTH = 16,   // operand/result width, >= 2, multiple of DIGIT
    parameter int DIGIT = 4     // bits processed per clock, 1..WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovfl,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0] c_last = CW'(NDIG - 1);

    // Two-state controller
    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    // Operand shift registers: the digit in flight always sits in the low bits
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    // Partial sum: each new digit enters at the top and earlier digits move
    // down, so after NDIG digits digit 0 has reached bit 0.
    logic [WIDTH-1:0] r_psum;

    // Held results
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovfl;
    logic             r_zero;
    logic             r_done;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [DIGIT:0]   w_dsum;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_sum_full;

    assign w_accept = (r_state == c_idle) && start;
    assign w_run    = (r_state == c_run);
    assign w_last   = w_run && (r_cnt == c_last);

    // One digit of the ripple add, DIGIT+1 bits so the top bit is the carry out
    assign w_dsum = {1'b0, r_opa[DIGIT-1:0]}
                  + {1'b0, r_opb[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // Carry into the digit's MSB recovered from the MSB sum bit:
    // sum = a ^ b ^ cin, hence cin = a ^ b ^ sum. For DIGIT=1 this is r_carry.
    assign w_cmsb = r_opa[DIGIT-1] ^ r_opb[DIGIT-1] ^ w_dsum[DIGIT-1];

    // Partial sum after the current digit has been shifted in at the top
    assign w_sum_full = (r_psum >> DIGIT)
                      | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave IDLE on start, return after the last digit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start)            w_state_nxt = c_run;
            c_run:   if (r_cnt == c_last)  w_state_nxt = c_idle;
            default:                       w_state_nxt = c_idle;
        endcase
    end

    // Controller outputs
    always_comb begin
        busy = (r_state == c_run);
    end

    // Operand capture on accept, then per-digit shift and carry propagation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_psum  <= '0;
        end else if (w_accept) begin
            // acc reads the held result as it stands at this edge, which
            // includes a result that completed on the previous edge
            r_opa   <= acc ? r_s : a;
            // subtraction as A + ~B + 1, the +1 entering as the initial carry
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_opa   <= r_opa >> DIGIT;
            r_opb   <= r_opb >> DIGIT;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            r_psum  <= w_sum_full;
        end
    end

    // Result registers change only on the completion edge; done is a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovfl <= 1'b0;
            r_zero <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_s    <= w_sum_full;
                r_cout <= w_dsum[DIGIT];
                r_ovfl <= w_cmsb ^ w_dsum[DIGIT];
                r_zero <= (w_sum_full == '0);
            end
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign ovfl = r_ovfl;
    assign zero = r_zero;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_serial
//  Description : Self-checking bench for addsub_serial. Directed cases on a
//                16/4 instance plus randomized runs on four parameter sets,
//                each compared cycle by cycle with an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_serial;

    localparam int SWEEP_CYC = 8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    int cyc = 0;
    int dcount;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Arithmetic reference: plain integer add/sub with range tests
    // ------------------------------------------------------------------
    function automatic void ref_op(input int w, input longint opa, input longint opb,
                                   input bit sb, output longint r, output bit co,
                                   output bit ov);
        longint md, half, raw, sa, sbv, sr;
        md   = longint'(1) << w;
        half = md >> 1;
        raw  = sb ? (opa - opb) : (opa + opb);
        r    = raw & (md - 1);
        co   = sb ? (opa >= opb) : (raw >= md);
        sa   = (opa >= half) ? opa - md : opa;
        sbv  = (opb >= half) ? opb - md : opb;
        sr   = sb ? (sa - sbv) : (sa + sbv);
        ov   = (sr >= half) || (sr < -half);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed instance, WIDTH=16 DIGIT=4
    // ------------------------------------------------------------------
    logic        dir_rst_n, dir_start, dir_sub, dir_acc;
    logic [15:0] dir_a, dir_b, dir_s;
    logic        dir_busy, dir_done, dir_cout, dir_ovfl, dir_zero;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dir (
        .clk   (clk),
        .rst_n (dir_rst_n),
        .start (dir_start),
        .a     (dir_a),
        .b     (dir_b),
        .sub   (dir_sub),
        .acc   (dir_acc),
        .busy  (dir_busy),
        .done  (dir_done),
        .s     (dir_s),
        .cout  (dir_cout),
        .ovfl  (dir_ovfl),
        .zero  (dir_zero)
    );

    initial begin
        dcount = 0;
        forever begin
            @(negedge clk);
            if (dir_done === 1'b1) dcount++;
        end
    end

    // Present a request, let it be accepted, then scramble the inputs
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                            input logic sb, input logic ac, output int k);
        dir_a = av; dir_b = bv; dir_sub = sb; dir_acc = ac; dir_start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        dir_start = 1'b0;
        dir_a   = 16'($urandom());
        dir_b   = 16'($urandom());
        dir_sub = 1'($urandom_range(0, 1));
        dir_acc = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (dir_done === 1'b1) begin
                lat = cyc - k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_op(input string nm, input logic [15:0] es, input logic ec,
                            input logic ev, input logic ez, input int lat);
        chk({nm, " latency"}, 64'(lat), 64'd4);
        chk({nm, " done"},    dir_done, 1);
        chk({nm, " busy"},    dir_busy, 0);
        chk({nm, " s"},       dir_s,    es);
        chk({nm, " cout"},    dir_cout, ec);
        chk({nm, " ovfl"},    dir_ovfl, ev);
        chk({nm, " zero"},    dir_zero, ez);
    endtask

    localparam logic [15:0] T_A   [5] = '{16'h0005, 16'h8000, 16'h1234, 16'hFFFF, 16'h7FFF};
    localparam logic [15:0] T_B   [5] = '{16'h0007, 16'h0001, 16'h1234, 16'h0001, 16'h0001};
    localparam logic        T_SUB [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [15:0] T_S   [5] = '{16'hFFFE, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
    localparam logic        T_C   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic        T_V   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic        T_Z   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // ------------------------------------------------------------------
    // Randomized instances, each with its own cycle-level model
    // ------------------------------------------------------------------
    logic rst_n;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int W = (gi == 0) ? 16 : (gi == 3) ? 32 : 8;
        localparam int D = (gi == 0) ? 4  : (gi == 1) ? 8  : (gi == 2) ? 1 : 8;
        localparam int N = W / D;

        logic         st, sb, ac, bz, dn, co, ov, zr;
        logic [W-1:0] av, bv, sv;

        longint m_s, p_s;
        bit     m_busy, m_done, m_co, m_ov, m_zr, p_co, p_ov;
        int     m_left, n_ops_m, n_ops_d;

        addsub_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (st),
            .a     (av),
            .b     (bv),
            .sub   (sb),
            .acc   (ac),
            .busy  (bz),
            .done  (dn),
            .s     (sv),
            .cout  (co),
            .ovfl  (ov),
            .zero  (zr)
        );

        function automatic logic [W-1:0] pick();
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                2:       return W'(longint'(1) << (W - 1));
                default: return W'($urandom());
            endcase
        endfunction

        // Model: a busy countdown of N edges, result computed arithmetically
        initial begin
            m_s = 0; m_busy = 0; m_done = 0; m_co = 0; m_ov = 0; m_zr = 1;
            m_left = 0; n_ops_m = 0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_s = 0; m_busy = 0; m_done = 0; m_co = 0; m_ov = 0; m_zr = 1;
                end else begin
                    m_done = 0;
                    if (m_busy) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_busy = 0; m_done = 1;
                            m_s = p_s; m_co = p_co; m_ov = p_ov; m_zr = (p_s == 0);
                            n_ops_m++;
                        end
                    end else if (st) begin
                        ref_op(W, ac ? m_s : longint'(av), longint'(bv), sb, p_s, p_co, p_ov);
                        m_busy = 1;
                        m_left = N;
                    end
                end
            end
        end

        // Compare every cycle out of reset
        initial begin
            n_ops_d = 0;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1) begin
                    n_cmp++;
                    if ({bz, dn, sv, co, ov, zr} !== {m_busy, m_done, W'(m_s), m_co, m_ov, m_zr}) begin
                        n_fail++;
                        $display("FAIL sweep W=%0d D=%0d cyc %0d: got busy=%b done=%b s=%h c=%b v=%b z=%b, expected busy=%b done=%b s=%h c=%b v=%b z=%b",
                                 W, D, cyc, bz, dn, sv, co, ov, zr,
                                 m_busy, m_done, W'(m_s), m_co, m_ov, m_zr);
                    end
                    if (dn === 1'b1) n_ops_d++;
                end
            end
        end

        // Stimulus: start held high at first (back-to-back), then random
        initial begin
            st = 1'b0; sb = 1'b0; ac = 1'b0; av = '0; bv = '0;
            wait (rst_n === 1'b1);
            for (int i = 0; i < SWEEP_CYC; i++) begin
                @(posedge clk);
                #1;
                st = (i < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
                av = pick();
                bv = pick();
                sb = 1'($urandom_range(0, 1));
                ac = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk);
            #1;
            st = 1'b0;
            repeat (N + 3) @(posedge clk);
            #1;
            n_cmp++;
            if (n_ops_d != n_ops_m || n_ops_m < 100) begin
                n_fail++;
                $display("FAIL sweep W=%0d D=%0d op count: got %0d dones, expected %0d (>=100)",
                         W, D, n_ops_d, n_ops_m);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence and summary
    // ------------------------------------------------------------------
    initial begin
        longint r;
        bit     mco, mov;
        int     k, lat, d0;

        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b1; dir_rst_n = 1'b1;
        dir_start = 1'b0; dir_sub = 1'b0; dir_acc = 1'b0; dir_a = '0; dir_b = '0;
        #1;
        rst_n = 1'b0; dir_rst_n = 1'b0;
        #1;
        chk("reset busy", dir_busy, 0);
        chk("reset done", dir_done, 0);
        chk("reset s",    dir_s,    0);
        chk("reset cout", dir_cout, 0);
        chk("reset ovfl", dir_ovfl, 0);
        chk("reset zero", dir_zero, 1);

        // pin the reference model with hand-worked values
        ref_op(16, 64'h8000, 64'h0001, 1'b1, r, mco, mov);
        chk("model 8000-1 s", r, 64'h7FFF);
        chk("model 8000-1 c", mco, 1);
        chk("model 8000-1 v", mov, 1);
        ref_op(8, 64'h7F, 64'h01, 1'b0, r, mco, mov);
        chk("model 7F+1 s", r, 64'h80);
        chk("model 7F+1 v", mov, 1);
        ref_op(16, 64'h0005, 64'h0007, 1'b1, r, mco, mov);
        chk("model 5-7 s", r, 64'hFFFE);
        chk("model 5-7 c", mco, 0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; dir_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic add
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0, k);
        chk("add busy after accept", dir_busy, 1);
        wait_done(k, lat);
        check_op("add 1234+4321", 16'h5555, 1'b0, 1'b0, 1'b0, lat);

        // accumulate, issued in the done cycle, with an ignored mid-run start
        start_op(16'hDEAD, 16'h0001, 1'b0, 1'b1, k);
        chk("acc accepted in done cycle", dir_busy, 1);
        chk("done single cycle", dir_done, 0);
        d0 = dcount;
        @(posedge clk);
        #1;
        dir_start = 1'b1; dir_acc = 1'b0; dir_a = 16'h7777;
        @(posedge clk);
        #1;
        dir_start = 1'b0;
        wait_done(k, lat);
        check_op("acc 5555+1", 16'h5556, 1'b0, 1'b0, 1'b0, lat);
        repeat (8) @(posedge clk);
        #1;
        chk("single done with mid-run start", 64'(dcount - d0), 64'd1);
        chk("idle after ignored start", dir_busy, 0);

        // signed and unsigned boundary vectors
        for (int i = 0; i < 5; i++) begin
            start_op(T_A[i], T_B[i], T_SUB[i], 1'b0, k);
            wait_done(k, lat);
            check_op($sformatf("vec%0d", i), T_S[i], T_C[i], T_V[i], T_Z[i], lat);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done cleared", i), dir_done, 0);
        end

        // reset two cycles into RUN aborts the operation
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0, k);
        @(posedge clk);
        #1;
        dir_rst_n = 1'b0;
        #1;
        chk("abort busy", dir_busy, 0);
        chk("abort s",    dir_s,    0);
        chk("abort zero", dir_zero, 1);
        chk("abort ovfl", dir_ovfl, 0);
        chk("abort done", dir_done, 0);
        @(posedge clk);
        #1;
        dir_rst_n = 1'b1;
        d0 = dcount;
        repeat (8) @(posedge clk);
        #1;
        chk("no done after abort", 64'(dcount - d0), 64'd0);
        start_op(16'hFFFF, 16'h01FF, 1'b0, 1'b1, k);
        wait_done(k, lat);
        check_op("acc after reset", 16'h01FF, 1'b0, 1'b0, 1'b0, lat);

        while (cyc < SWEEP_CYC + 40) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
